// File: rtl/arq_pkg.sv
// Shared constants and access-word layout for the access request queue.
// Also used by the scheduler tree and the downstream memory port.
package arq_pkg;

    localparam int ARQ_DATA_WIDTH_DEF = 132;
    localparam int ARQ_DEPTH_DEF      = 4;

    localparam int ARQ_ADDR_W    = 64;
    localparam int ARQ_OP_W      = 4;
    localparam int ARQ_PAYLOAD_W = 64;

    // Field view of one 132-bit access word (MSB first).
    typedef struct packed {
        logic [ARQ_ADDR_W-1:0]    addr;
        logic [ARQ_OP_W-1:0]      op;
        logic [ARQ_PAYLOAD_W-1:0] payload;
    } access_word_t;

endpackage

// File: rtl/arq_storage.sv
// DEPTH x DATA_WIDTH register file for the access request queue.
// One synchronous write port, one asynchronous read port; contents not reset.
module arq_storage #(
    parameter int DATA_WIDTH = 132,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write the accepted entry into its slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/access_request_queue.sv
// Per-leaf request FIFO feeding the access scheduler tree.
// Optional head-age / urgent output enabled by defining ARQ_AGE_EN.
module access_request_queue
    import arq_pkg::*;
#(
    parameter int DATA_WIDTH = ARQ_DATA_WIDTH_DEF,
    parameter int DEPTH      = ARQ_DEPTH_DEF,
`ifdef ARQ_AGE_EN
    parameter int AGE_LIMIT  = 15,
`endif
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] d_IN,
    output logic                  full,
    output logic                  req,
    output logic [DATA_WIDTH-1:0] d_OUT,
    input  logic                  serv,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
`ifdef ARQ_AGE_EN
    ,
    output logic                  urgent
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_next;
    logic                  full_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  push_ok;
    logic                  pop_ok;
    logic [DATA_WIDTH-1:0] head;

    assign req     = (count_q != '0);
    assign push_ok = push && !full_q;
    assign pop_ok  = serv && req;

    assign count_next = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

    arq_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (d_IN),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointers, occupancy and registered full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_next;
            full_q  <= (count_next == CNT_W'(DEPTH));
        end
    end

    // Sticky misuse flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push && full_q) begin
                ovf_q <= 1'b1;
            end
            if (serv && !req) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign full      = full_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign d_OUT     = req ? head : '0;

`ifdef ARQ_AGE_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);

    logic [AGE_W-1:0] age_q;

    // Age of the current head entry, saturating at AGE_LIMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= '0;
        end else if (!req || pop_ok) begin
            age_q <= '0;
        end else if (age_q != AGE_W'(AGE_LIMIT)) begin
            age_q <= age_q + AGE_W'(1);
        end
    end

    assign urgent = req && (age_q == AGE_W'(AGE_LIMIT));
`endif

endmodule

// File: tb/tb_access_request_queue.sv
// Randomized self-checking bench for access_request_queue.
// Reference model is a queue of words plus sticky flags.
module tb_access_request_queue;

    localparam int DW    = 132;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef ARQ_AGE_EN
    localparam int AL    = 3;
`endif

    logic          clk;
    logic          rst;
    logic          push;
    logic [DW-1:0] d_IN;
    logic          full;
    logic          req;
    logic [DW-1:0] d_OUT;
    logic          serv;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;
`ifdef ARQ_AGE_EN
    logic          urgent;
`endif

    access_request_queue #(
        .DATA_WIDTH (DW),
`ifdef ARQ_AGE_EN
        .AGE_LIMIT  (AL),
`endif
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .d_IN      (d_IN),
        .full      (full),
        .req       (req),
        .d_OUT     (d_OUT),
        .serv      (serv),
        .count     (count),
        .overflow  (overflow),
`ifdef ARQ_AGE_EN
        .urgent    (urgent),
`endif
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mq[$];
    logic          m_ovf;
    logic          m_unf;
    int            m_age;

    task automatic check(input string tag,
                         input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[DW-1:0];
    endfunction

    // Apply the queue rules to the model for one clock edge.
    task automatic model_edge(input logic r, input logic p,
                              input logic s, input logic [DW-1:0] d);
        int  sz;
        bit  acc_push;
        bit  acc_pop;
        sz = mq.size();
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_age = 0;
        end else begin
            acc_push = p && (sz < DEPTH);
            acc_pop  = s && (sz > 0);
            if (p && sz == DEPTH) m_ovf = 1'b1;
            if (s && sz == 0) m_unf = 1'b1;
            if (sz == 0 || acc_pop) m_age = 0;
            else if (m_age < 1000) m_age = m_age + 1;
            if (acc_pop) void'(mq.pop_front());
            if (acc_push) mq.push_back(d);
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        check("req", DW'(req), DW'(mq.size() > 0));
        check("d_OUT", d_OUT, head);
        check("count", DW'(count), DW'(mq.size()));
        check("full", DW'(full), DW'(mq.size() == DEPTH));
        check("overflow", DW'(overflow), DW'(m_ovf));
        check("underflow", DW'(underflow), DW'(m_unf));
`ifdef ARQ_AGE_EN
        check("urgent", DW'(urgent),
              DW'(mq.size() > 0 && m_age >= AL));
`endif
    endtask

    // Drive one cycle of inputs, advance the model, check after the edge.
    task automatic step(input logic r, input logic p,
                        input logic s, input logic [DW-1:0] d);
        rst  = r;
        push = p;
        serv = s;
        d_IN = d;
        @(posedge clk);
        model_edge(r, p, s, d);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst   = 1'b1;
        push  = 1'b0;
        serv  = 1'b0;
        d_IN  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_age = 0;
        @(negedge clk);

        // Reset, then idle.
        step(1, 0, 0, '0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, rand_word());

        // Three pushes, then three services.
        step(0, 1, 0, DW'(32'hA));
        step(0, 1, 0, DW'(32'hB));
        step(0, 1, 0, DW'(32'hC));
        for (int i = 0; i < 3; i++) step(0, 0, 1, '0);

        // Fill, then push with serv while full.
        for (int i = 0; i < 4; i++) step(0, 1, 0, rand_word());
        step(0, 1, 1, DW'(32'hE));
        step(0, 0, 1, '0);

        // Simultaneous push/serv across pointer wrap from count=2.
        step(1, 0, 0, '0);
        step(0, 1, 0, rand_word());
        step(0, 1, 0, rand_word());
        for (int i = 0; i < 10; i++) step(0, 1, 1, rand_word());
        for (int i = 0; i < 2; i++) step(0, 0, 1, '0);

        // serv while empty with a push, then reset mid-stream.
        step(0, 1, 1, DW'(32'h5));
        step(0, 1, 0, rand_word());
        step(0, 1, 0, rand_word());
        step(1, 1, 1, rand_word());
        step(0, 0, 0, '0);

`ifdef ARQ_AGE_EN
        // Head ageing up to the urgent threshold.
        step(0, 1, 0, rand_word());
        for (int i = 0; i < 6; i++) step(0, 0, 0, '0);
        step(0, 0, 1, '0);
        step(0, 0, 0, '0);
`endif

        // Randomized phases with varying push/serv bias.
        for (int ph = 0; ph < 4; ph++) begin
            int pp;
            int sp;
            pp = 30 + ph * 20;
            sp = 90 - ph * 20;
            for (int i = 0; i < 500; i++) begin
                step(($urandom_range(0, 199) == 0),
                     ($urandom_range(0, 99) < pp),
                     ($urandom_range(0, 99) < sp),
                     rand_word());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/access_request_queue.md
Name: access_request_queue

Overview:
- Per-requester FIFO sitting directly upstream of the access scheduler tree, one instance per tree leaf.
- Buffers outgoing access words (address/op/data, DATA_WIDTH bits) from a core/interconnect port.
- Presents the head entry to the tree as a req/data pair and retires it when the tree returns the per-leaf service strobe.
- Decouples requester issue rate from tree arbitration, so a losing leaf does not stall its source.

Parameters:
DATA_WIDTH, 132, width of one access word; matches tree data width
DEPTH, 4, entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  synchronous, active-high reset
push  input  1  requester writes d_IN this cycle
d_IN  input  DATA_WIDTH  access word to enqueue
full  output  1  no free entry; registered
req  output  1  head valid; drives the tree leaf req
d_OUT  output  DATA_WIDTH  head access word to the tree leaf
serv  input  1  tree is servicing this leaf this cycle; retire head
count  output  CNT_W  current occupancy
overflow  output  1  sticky: push seen while full
underflow  output  1  sticky: serv seen while req low

Behaviour:
- Reset, when rst is high at posedge: wr_ptr=0, rd_ptr=0, count=0, full=0, req=0, overflow=0, underflow=0. Storage contents are not reset. rst has priority over push/serv in that cycle.
- req = (count != 0), decoded from registered count. d_OUT = mem[rd_ptr] when req, else all-zero. No combinational path from serv or push to any output.
- Push accepted iff push && !full. Data is written at mem[wr_ptr], wr_ptr increments and wraps modulo DEPTH.
- Pop accepted iff serv && req. rd_ptr increments and wraps modulo DEPTH.
- Latency: an accepted push into an empty queue gives req=1 and d_OUT=that word on the next cycle (1-cycle fall-through). An accepted pop shows the next head the following cycle.
- Simultaneous push and pop, not full: both are accepted, count unchanged, ordering preserved.
- Push while full: rejected even if serv is high that cycle, because full is a registered view of the current state. overflow is set. Storage and pointers are unchanged.
- Push while empty with serv high: push is accepted; serv is ignored and sets underflow.
- count update: count + accepted_push - accepted_pop. full = (count_next == DEPTH), registered.
- overflow/underflow clear only on rst.
- The tree may hold serv high for multiple cycles; each cycle retires one entry.
- A reset mid-stream discards all entries. req drops the cycle after rst is sampled.

Optional Feature:
- Macro ARQ_AGE_EN.
- Defined:
  - Adds parameter AGE_LIMIT (default 15) and output urgent (1 bit).
  - A head-age counter of width $clog2(AGE_LIMIT+1):
    - clears on rst, on an accepted pop, and while req=0;
    - otherwise increments, saturating at AGE_LIMIT.
  - urgent = req && (age == AGE_LIMIT), registered.
  - Intended to feed a future priority override in the tree's conflict resolution.
- Undefined: no urgent port, no age counter, zero extra flops.

Decomposition:
- Package arq_pkg:
  - ARQ_DATA_WIDTH_DEF (132) and ARQ_DEPTH_DEF (4) constants;
  - access-word field typedef (addr/op/payload slices of the 132-bit word), shared with the tree and the downstream memory port.
- One sub-module, arq_storage: DEPTH x DATA_WIDTH register file with 1 write port and 1 async read port. Pointer, count and flag logic stay in the top.

Test Plan:
- Reset then idle: req=0, full=0, count=0, d_OUT=0, overflow=underflow=0 for 10 cycles.
- Push 0xA, 0xB, 0xC on consecutive cycles, serv low: req=1 one cycle after the first push, d_OUT=0xA, count reaches 3. Then serv for 3 cycles: d_OUT goes 0xA, 0xB, 0xC, then req=0, count=0.
- Fill with 4 pushes (DEPTH=4): full=1, count=4. Fifth push with serv=1 the same cycle: push dropped, overflow=1, one pop occurs, count=3, full=0 the next cycle.
- Wrap-around: 10 cycles with push and serv both high from count=2: count stays 2, output order matches input order across pointer wrap.
- serv=1 while empty with push=1 of 0x5: underflow=1, next cycle req=1, d_OUT=0x5, count=1. Assert rst mid-stream with count=3: the next cycle has req=0, count=0, and the sticky flags are cleared.
- ARQ_AGE_EN, AGE_LIMIT=3: push 1 entry, hold serv low. urgent=1 from the 4th cycle after req rises. serv for 1 cycle: urgent=0 the next cycle.
